// File: rtl/beat_sequencer_pkg.sv
// rtl/beat_sequencer_pkg.sv - beat-type, stage and phase definitions shared with store and accumulator
package beat_sequencer_pkg;

    localparam logic SCAN   = 1'b1;
    localparam logic ACTION = 1'b0;

    localparam logic [1:0] STG_A0 = 2'd0;
    localparam logic [1:0] STG_A1 = 2'd1;
    localparam logic [1:0] STG_A2 = 2'd2;
    localparam logic [1:0] STG_A3 = 2'd3;

    localparam int DEFAULT_TUBE_DEPTH = 32;
    localparam int GAP_W              = 4;

    typedef enum logic [1:0] {
        PH_OUT,
        PH_IN,
        PH_GAP
    } phase_t;

    typedef enum logic [1:0] {
        CTL_STOPPED,
        CTL_RUNNING,
        CTL_STEPPING
    } ctl_t;

endpackage

// File: rtl/beat_phase_gen.sv
// rtl/beat_phase_gen.sv - OUT/IN/GAP beat phase generator with registered strobes
module beat_phase_gen
    import beat_sequencer_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic w_CLK,
    input  logic w_RST,
    output logic ready_out,
    output logic ready_in,
    output logic out_end,
    output logic beat_end,
    output logic beat_start
);

    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

    phase_t           phase;
    logic [GAP_W-1:0] gap_cnt;

    assign out_end    = (phase == PH_OUT);
    assign beat_end   = (phase == PH_IN);
    // beat_start marks the edge that enters OUT; reset parks in an empty GAP so OUT follows release
    assign beat_start = ((phase == PH_IN) && (GAP_CYCLES == 0)) ||
                        ((phase == PH_GAP) && (gap_cnt == '0));

    always_ff @(posedge w_CLK) begin
        if (w_RST) begin
            phase     <= PH_GAP;
            gap_cnt   <= '0;
            ready_out <= 1'b0;
            ready_in  <= 1'b0;
        end else begin
            case (phase)
                PH_OUT: begin
                    phase     <= PH_IN;
                    ready_out <= 1'b0;
                    ready_in  <= 1'b1;
                end
                PH_IN: begin
                    ready_in <= 1'b0;
                    if (GAP_CYCLES == 0) begin
                        phase     <= PH_OUT;
                        ready_out <= 1'b1;
                    end else begin
                        phase   <= PH_GAP;
                        gap_cnt <= GAP_LAST;
                    end
                end
                default: begin
                    if (gap_cnt == '0) begin
                        phase     <= PH_OUT;
                        ready_out <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - master beat timing: scan/action interleave, run/step/halt control, scan line
module beat_sequencer
    import beat_sequencer_pkg::*;
#(
    parameter int TUBE_DEPTH = DEFAULT_TUBE_DEPTH,
    parameter int GAP_CYCLES = 0,
    parameter int N_ACTIONS  = 4
) (
    input  logic                          w_CLK,
    input  logic                          w_RST,
    input  logic                          w_RUN,
    input  logic                          w_STEP,
    input  logic                          w_HALT,
    output logic                          ready_out,
    output logic                          ready_in,
    output logic                          w_HS,
    output logic                          w_ACTION,
    output logic [1:0]                    b_STAGE,
    output logic                          w_STOPPED,
    output logic [$clog2(TUBE_DEPTH)-1:0] b_SCAN_LINE
);

    localparam int             SLW        = $clog2(TUBE_DEPTH);
    localparam logic [SLW-1:0] LAST_LINE  = SLW'(TUBE_DEPTH - 1);
    localparam logic [1:0]     LAST_STAGE = 2'(N_ACTIONS - 1);

    logic out_end;
    logic beat_end;
    logic beat_start;

    beat_phase_gen #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_phase (
        .w_CLK     (w_CLK),
        .w_RST     (w_RST),
        .ready_out (ready_out),
        .ready_in  (ready_in),
        .out_end   (out_end),
        .beat_end  (beat_end),
        .beat_start(beat_start)
    );

    ctl_t       ctl;
    ctl_t       ctl_d;
    logic       step_latch;
    logic       run_prev;
    logic       halt_seen;
    logic       hs_pend;
    logic       stopped_pend;
    logic       hs_d;
    logic       stopped_d;
    logic [1:0] stage_d;
    logic       clear_step;
    logic       run_edge;
    logic       start_req;

    assign run_edge  = w_RUN && !run_prev;
    assign start_req = run_edge || step_latch;

    // Next-beat decisions are taken at the end of IN; the beat type is applied when OUT begins
    always_comb begin
        ctl_d      = ctl;
        stage_d    = b_STAGE;
        hs_d       = hs_pend;
        stopped_d  = stopped_pend;
        clear_step = 1'b0;
        if (beat_end) begin
            if (w_HS == SCAN) begin
                if (ctl != CTL_STOPPED) begin
                    hs_d = ACTION;
                end else if (start_req) begin
                    ctl_d      = run_edge ? CTL_RUNNING : CTL_STEPPING;
                    clear_step = 1'b1;
                    hs_d       = ACTION;
                    stopped_d  = 1'b0;
                end else begin
                    hs_d = SCAN;
                end
            end else begin
                hs_d = SCAN;
                if ((b_STAGE == STG_A2 && halt_seen) ||
                    (b_STAGE == LAST_STAGE && (!w_RUN || ctl == CTL_STEPPING))) begin
                    ctl_d     = CTL_STOPPED;
                    stopped_d = 1'b1;
                    stage_d   = STG_A0;
                end else if (b_STAGE == LAST_STAGE) begin
                    stage_d = STG_A0;
                end else begin
                    stage_d = b_STAGE + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge w_CLK) begin
        if (w_RST) begin
            w_HS         <= SCAN;
            w_ACTION     <= 1'b0;
            b_STAGE      <= STG_A0;
            w_STOPPED    <= 1'b1;
            b_SCAN_LINE  <= '0;
            step_latch   <= 1'b0;
            run_prev     <= 1'b1;
            halt_seen    <= 1'b0;
            ctl          <= CTL_STOPPED;
            hs_pend      <= SCAN;
            stopped_pend <= 1'b1;
        end else begin
            run_prev     <= w_RUN;
            ctl          <= ctl_d;
            b_STAGE      <= stage_d;
            hs_pend      <= hs_d;
            stopped_pend <= stopped_d;

            // a run edge that starts the machine also swallows a coincident step request
            if (clear_step) begin
                step_latch <= 1'b0;
            end else if (w_STEP && w_STOPPED) begin
                step_latch <= 1'b1;
            end

            if (beat_end) begin
                halt_seen <= 1'b0;
            end else if (out_end && w_HS == ACTION && b_STAGE == STG_A2 && w_HALT) begin
                halt_seen <= 1'b1;
            end

            if (beat_end && w_HS == SCAN) begin
                b_SCAN_LINE <= (b_SCAN_LINE == LAST_LINE) ? '0 : b_SCAN_LINE + SLW'(1);
            end

            if (beat_start) begin
                w_HS      <= hs_d;
                w_ACTION  <= ~hs_d;
                w_STOPPED <= stopped_d;
            end
        end
    end

endmodule

// File: tb/tb_beat_sequencer.sv
// tb/tb_beat_sequencer.sv - table-driven beat checks with expected-beat scoreboard
module tb_beat_sequencer;

    logic       clk;
    logic       rst0, rst3;
    logic       w_RUN, w_STEP, w_HALT;
    logic       run3, step3, halt3;
    logic       ro0, ri0, hs0, act0, stp0;
    logic [1:0] stg0;
    logic [4:0] line0;
    logic       ro3, ri3, hs3, act3, stp3;
    logic [1:0] stg3;
    logic [4:0] line3;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    beat_sequencer #(.TUBE_DEPTH(32), .GAP_CYCLES(0), .N_ACTIONS(4)) dut0 (
        .w_CLK(clk), .w_RST(rst0), .w_RUN(w_RUN), .w_STEP(w_STEP), .w_HALT(w_HALT),
        .ready_out(ro0), .ready_in(ri0), .w_HS(hs0), .w_ACTION(act0),
        .b_STAGE(stg0), .w_STOPPED(stp0), .b_SCAN_LINE(line0)
    );

    beat_sequencer #(.TUBE_DEPTH(32), .GAP_CYCLES(3), .N_ACTIONS(4)) dut3 (
        .w_CLK(clk), .w_RST(rst3), .w_RUN(run3), .w_STEP(step3), .w_HALT(halt3),
        .ready_out(ro3), .ready_in(ri3), .w_HS(hs3), .w_ACTION(act3),
        .b_STAGE(stg3), .w_STOPPED(stp3), .b_SCAN_LINE(line3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       run_o, run_i, step_i, halt_o;
        logic       e_hs;
        logic [1:0] e_stage;
        logic       e_stopped;
        logic [4:0] e_line;
    } vec_t;

    typedef struct {
        int         idx;
        logic [8:0] exp;
    } beat_t;

    vec_t  vecs[$];
    beat_t exp_q[$];

    task automatic add(input logic ro, input logic ri, input logic st, input logic ho,
                       input logic hs, input logic [1:0] sg, input logic sp, input logic [4:0] ln);
        vec_t v;
        v.run_o = ro; v.run_i = ri; v.step_i = st; v.halt_o = ho;
        v.e_hs = hs; v.e_stage = sg; v.e_stopped = sp; v.e_line = ln;
        vecs.push_back(v);
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk_n(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Scoreboard: each IN phase of dut0 retires one expected beat {hs, stage, stopped, line}
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ((ro0 && ri0) || (act0 !== ~hs0)) begin
                errors++;
                $display("FAIL strobe_invariant ro=%b ri=%b hs=%b action=%b", ro0, ri0, hs0, act0);
            end
            if (ri0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat actual=%h required=none", {hs0, stg0, stp0, line0});
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    if ({hs0, stg0, stp0, line0} !== b.exp) begin
                        errors++;
                        $display("FAIL beat%0d actual hs=%b stg=%0d stop=%b line=%0d required hs=%b stg=%0d stop=%b line=%0d",
                                 b.idx, hs0, stg0, stp0, line0, b.exp[8], b.exp[7:6], b.exp[5], b.exp[4:0]);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst0 = 1'b1; rst3 = 1'b1;
        w_RUN = 1'b0; w_STEP = 1'b0; w_HALT = 1'b0;
        run3 = 1'b0; step3 = 1'b0; halt3 = 1'b0;

        // stopped scan-only: 33 beats, line wraps 31 -> 0
        for (int k = 0; k < 33; k++) add(0, 0, 0, 0, 1, 0, 1, 5'(k % 32));
        add(0, 1, 0, 0, 1, 0, 1, 1);        // run edge at end of scan
        add(1, 1, 0, 0, 0, 0, 0, 2);        // A0
        add(1, 1, 0, 0, 1, 1, 0, 2);
        add(0, 0, 0, 0, 0, 1, 0, 3);        // A1, run falls
        add(0, 0, 0, 0, 1, 2, 0, 3);
        add(0, 0, 0, 0, 0, 2, 0, 4);        // A2
        add(0, 0, 0, 0, 1, 3, 0, 4);
        add(0, 0, 0, 0, 0, 3, 0, 5);        // A3 then stop
        add(0, 0, 0, 0, 1, 0, 1, 5);
        add(0, 0, 0, 0, 1, 0, 1, 6);
        add(0, 1, 0, 0, 1, 0, 1, 7);        // restart
        add(1, 1, 0, 0, 0, 0, 0, 8);
        add(1, 1, 0, 0, 1, 1, 0, 8);
        add(1, 1, 0, 0, 0, 1, 0, 9);
        add(1, 1, 0, 0, 1, 2, 0, 9);
        add(1, 1, 0, 1, 0, 2, 0, 10);       // A2 with HLT
        add(1, 1, 0, 0, 1, 0, 1, 10);       // held run does not restart
        add(1, 1, 0, 0, 1, 0, 1, 11);
        add(0, 1, 0, 0, 1, 0, 1, 12);       // new edge restarts
        add(1, 1, 0, 0, 0, 0, 0, 13);
        add(1, 1, 0, 0, 1, 1, 0, 13);
        add(1, 1, 0, 0, 0, 1, 0, 14);
        add(1, 1, 0, 0, 1, 2, 0, 14);
        add(0, 0, 0, 1, 0, 2, 0, 15);       // HLT with run falling
        add(0, 0, 0, 0, 1, 0, 1, 15);
        add(0, 0, 1, 0, 1, 0, 1, 16);       // step pulse
        add(0, 0, 0, 0, 1, 0, 1, 17);
        add(0, 0, 0, 0, 0, 0, 0, 18);       // stepped A0
        add(0, 0, 0, 0, 1, 1, 0, 18);
        add(0, 0, 1, 0, 0, 1, 0, 19);       // step while running ignored
        add(0, 0, 0, 0, 1, 2, 0, 19);
        add(1, 1, 0, 0, 0, 2, 0, 20);
        add(1, 1, 0, 0, 1, 3, 0, 20);
        add(1, 1, 0, 0, 0, 3, 0, 21);       // step ends after A3 despite run=1
        add(1, 1, 0, 0, 1, 0, 1, 21);
        add(1, 1, 0, 0, 1, 0, 1, 22);
        add(0, 0, 0, 0, 1, 0, 1, 23);
        add(0, 1, 1, 0, 1, 0, 1, 24);       // run edge and step together
        add(1, 1, 0, 0, 0, 0, 0, 25);
        add(1, 1, 0, 0, 1, 1, 0, 25);
        add(1, 1, 0, 0, 0, 1, 0, 26);
        add(1, 1, 0, 0, 1, 2, 0, 26);
        add(1, 1, 0, 0, 0, 2, 0, 27);
        add(1, 1, 0, 0, 1, 3, 0, 27);
        add(1, 1, 0, 0, 0, 3, 0, 28);       // A3 with run high continues
        add(1, 1, 0, 0, 1, 0, 0, 28);
        add(0, 0, 0, 0, 0, 0, 0, 29);
        add(0, 0, 0, 0, 1, 1, 0, 29);
        add(0, 0, 0, 0, 0, 1, 0, 30);
        add(0, 0, 0, 0, 1, 2, 0, 30);
        add(0, 0, 0, 0, 0, 2, 0, 31);
        add(0, 0, 0, 0, 1, 3, 0, 31);       // line wraps while running
        add(0, 0, 0, 0, 0, 3, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 1, 1);        // no leftover step latch

        repeat (3) @(negedge clk);
        chk_b("rst_ready_out", ro0, 1'b0);
        chk_b("rst_ready_in", ri0, 1'b0);
        chk_b("rst_hs", hs0, 1'b1);
        chk_b("rst_action", act0, 1'b0);
        chk_n("rst_stage", {3'b0, stg0}, 5'd0);
        chk_b("rst_stopped", stp0, 1'b1);
        chk_n("rst_line", line0, 5'd0);
        rst0 = 1'b0;
        rst3 = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            n = 0;
            while (!ro0 && n < 8) begin
                @(negedge clk);
                n++;
            end
            chk_b("out_phase_wait", ro0, 1'b1);
            w_RUN = vecs[i].run_o; w_HALT = vecs[i].halt_o; w_STEP = 1'b0;
            exp_q.push_back('{i, {vecs[i].e_hs, vecs[i].e_stage, vecs[i].e_stopped, vecs[i].e_line}});
            @(negedge clk);
            w_RUN = vecs[i].run_i; w_STEP = vecs[i].step_i; w_HALT = 1'b0;
        end
        @(negedge clk);
        mon_en = 1'b0;
        chk_n("beats_left", 5'(exp_q.size()), 5'd0);

        // GAP_CYCLES=3 instance: 5-cycle beats, then reset in mid-IN
        rst3 = 1'b1;
        repeat (2) @(negedge clk);
        rst3 = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk_b("g3_ready_out", ro3, (i % 5) == 1);
            chk_b("g3_ready_in", ri3, (i % 5) == 2);
            chk_b("g3_hs", hs3, 1'b1);
            chk_n("g3_line", line3, 5'((i + 2) / 5));
        end
        rst3 = 1'b1;
        @(negedge clk);
        chk_b("g3_rst_ready_in", ri3, 1'b0);
        chk_b("g3_rst_ready_out", ro3, 1'b0);
        chk_n("g3_rst_line", line3, 5'd0);
        rst3 = 1'b0;
        @(negedge clk);
        chk_b("g3_release_ready_out", ro3, 1'b1);
        chk_b("g3_release_ready_in", ri3, 1'b0);
        chk_b("g3_release_stopped", stp3, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
- Master timing controller for the reduced machine. Generates the per-beat read/write strobes (ready_out, ready_in) and the SCAN/ACTION beat type (w_HS, w_ACTION) that drive the main store and accumulator.
- Sequences the four-action instruction cycle and tracks the store's scan beam line.
- Implements run/stop, single-step and HLT stopping. While stopped it keeps issuing scan beats so store zeroing and scan stay live.

Parameters:
- TUBE_DEPTH, 32, lines per tube; scan-line counter modulus.
- GAP_CYCLES, 0, idle cycles inserted after each beat's IN phase (0..15).
- N_ACTIONS, 4, action beats per instruction; fixed at 4, stage encoding is 2 bits.

Ports:
- w_CLK  in  1  clock, rising edge.
- w_RST  in  1  synchronous reset, active high.
- w_RUN  in  1  run/stop switch level; 1 = run.
- w_STEP  in  1  single-step request, one-cycle pulse.
- w_HALT  in  1  decoded HLT; sampled only in the OUT phase of ACTION stage 2.
- ready_out  out  1  OUT phase strobe; store and accumulator drive outputs.
- ready_in  out  1  IN phase strobe; store and accumulator capture.
- w_HS  out  1  1 = SCAN beat, 0 = ACTION beat; constant for a whole beat.
- w_ACTION  out  1  1 during ACTION beats; always equal to !w_HS.
- b_STAGE  out  [0:1]  action index 0..3 of the current or next action beat.
- w_STOPPED  out  1  machine is stopped; only scan beats are issued.
- b_SCAN_LINE  out  [0:$clog2(TUBE_DEPTH)-1]  current scan beam line.

Behaviour:
- All outputs are registered.
- Reset values: ready_out=0, ready_in=0, w_HS=1, w_ACTION=0, b_STAGE=0, w_STOPPED=1, b_SCAN_LINE=0, step latch=0, run_prev=1.
  - run_prev=1 means reset never counts as a run edge.
- Reset mid-beat abandons the beat immediately, with no completing IN strobe. The first ready_out is the cycle after w_RST falls.
- Phase FSM, states OUT -> IN -> GAP(GAP_CYCLES cycles) -> OUT.
  - With GAP_CYCLES=0, GAP is skipped and a beat is 2 cycles.
  - ready_out=1 only in OUT; ready_in=1 only in IN; both 0 in GAP.
  - ready_out and ready_in are never high together.
- Beat order while running: S, A0, S, A1, S, A2, S, A3, S, A0, ...
  - Every action beat is preceded by exactly one scan beat.
  - b_STAGE advances 3 -> 0 at the end of A3's IN phase.
- b_SCAN_LINE increments at the end of every scan beat's IN phase, running or stopped. It wraps TUBE_DEPTH-1 -> 0. Action beats never advance it.
- Stopped: only scan beats are issued, b_STAGE is held at 0, and w_STOPPED=1.
- Start condition: a rising edge of w_RUN (w_RUN=1 and run_prev=0), or the step latch set.
  - Sampled at the end of a scan beat's IN phase.
  - That scan beat then counts as the S before A0; the next beat is A0 and w_STOPPED falls with it.
- w_STEP pulse: sets the step latch when w_STOPPED=1. It is ignored while running. The latch clears when A0 starts.
- Single step runs exactly A0..A3, then stops. This happens regardless of w_RUN.
- Stop at instruction boundary: at the end of A3's IN phase, if w_RUN=0 or the instruction was a step, the machine stops. The following beat is a scan beat with w_STOPPED=1.
- HLT: w_HALT=1 sampled in A2's OUT phase stops the machine at the end of A2's IN phase.
  - A3 is not issued and b_STAGE returns to 0.
  - Restart requires a new w_RUN rising edge or w_STEP. A w_RUN level held high does not restart.
- Simultaneous events:
  - w_HALT with w_RUN falling in A2: stop after A2 (halt wins).
  - w_STEP on the same cycle as a run edge: run edge wins and the step latch is cleared.
- run_prev updates every cycle.

Decomposition:
- Shared package, shared with the main store and accumulator: beat-type constants (SCAN=1, ACTION=0), stage encodings (STG_A0..STG_A3), a phase enum typedef (PH_OUT, PH_IN, PH_GAP), and the default TUBE_DEPTH.
- One natural sub-module, beat_phase_gen: the OUT/IN/GAP FSM with gap counter. It emits beat_end.
- The run/step/halt control FSM (STOPPED, RUNNING, STEPPING) and the scan counter stay in the top level.

Test Plan:
- Reset, w_RUN=0, GAP=0: w_STOPPED=1. ready_out/ready_in alternate every cycle with w_HS=1 throughout. b_SCAN_LINE goes 0,1,..,31,0, advancing every 2 cycles.
- w_RUN 0->1 while stopped: after the current scan beat, beats are A0,S,A1,S,A2,S,A3,S,A0 with b_STAGE 0,1,2,3,0 and w_ACTION=!w_HS. The scan line advances only on S beats.
- Running, w_RUN falls during A1: A2 and A3 complete, then scan-only. w_STOPPED rises after A3's IN phase.
- Running, w_HALT=1 in A2's OUT phase: no A3 is issued and w_STOPPED=1. Holding w_RUN=1 does not restart; toggling w_RUN 0->1 restarts at A0.
- Stopped, single w_STEP pulse: exactly 4 action beats A0..A3, then stopped. A w_STEP pulse while running has no effect.
- GAP_CYCLES=3: each beat is 5 cycles (OUT, IN, 3 idle). A w_RST pulse mid-IN gives ready_in=0 and b_SCAN_LINE=0 the next cycle, and ready_out=1 one cycle after release.
